// File: rtl/bullet_if.sv
// Scan inputs and sprite outputs shared between the bullet layer and the pixel-colour path.
interface bullet_if;
   logic [9:0] xx;
   logic [9:0] yy;
   logic       aactive;
   logic [2:0] state;
   logic       HeartSpriteOn;
   logic       BulletSpriteOn;
   logic       hit;
   logic [3:0] hit_count;

   modport master (
      output xx, yy, aactive, state, HeartSpriteOn,
      input  BulletSpriteOn, hit, hit_count
   );

   modport slave (
      input  xx, yy, aactive, state, HeartSpriteOn,
      output BulletSpriteOn, hit, hit_count
   );
endinterface

// File: rtl/bullet_engine.sv
// Enemy bullet layer: moving bullet pool, per-frame spawn/update, heart collision reporting.
module bullet_engine #(
   parameter int unsigned NUM_BULLETS  = 4,
   parameter int unsigned SIZE         = 8,
   parameter int unsigned SPEED        = 2,
   parameter int unsigned SPAWN_FRAMES = 30,
   parameter int unsigned BOX_X0       = 200,
   parameter int unsigned BOX_X1       = 440,
   parameter int unsigned BOX_Y0       = 260,
   parameter int unsigned BOX_Y1       = 420,
   parameter logic [2:0]  FIGHT_STATE  = 3'd2
) (
   input  logic    Pclk,
   input  logic    RESET,
   bullet_if.slave bus
);

   localparam int unsigned CW = (SPAWN_FRAMES > 1) ? $clog2(SPAWN_FRAMES) : 1;

   // The tick cycle is the UPDATE phase; every other cycle is SCAN.
   localparam logic [0:0] SCAN   = 1'b0;
   localparam logic [0:0] UPDATE = 1'b1;

   // Spawn heights come from a 6-bit offset, so the box must be tall enough for it.
   if (BOX_Y1 - BOX_Y0 - SIZE < 64) begin : g_box_check
      $error("bullet_engine: box too short for spawn range");
   end

   logic [NUM_BULLETS-1:0] act_q, act_d;
   logic [NUM_BULLETS-1:0] flag_q, flag_d;
   logic [NUM_BULLETS-1:0] cov_c, newhit_c;
   logic [9:0]             bx_q [NUM_BULLETS];
   logic [9:0]             bx_d [NUM_BULLETS];
   logic [9:0]             by_q [NUM_BULLETS];
   logic [9:0]             by_d [NUM_BULLETS];
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [7:0]             lfsr_q, lfsr_d;
   logic                   bso_q, bso_d;
   logic                   hit_q, hit_d;
   logic [3:0]             hcnt_q, hcnt_d;
   logic [0:0]             phase_c;
   logic                   tick_c, en_c, spawned_c;

   assign tick_c  = (bus.xx == 10'd0) && (bus.yy == 10'd480);
   assign en_c    = (bus.state == FIGHT_STATE);
   assign phase_c = tick_c ? UPDATE : SCAN;

   // Per-bullet pixel coverage for the current scan position.
   always_comb begin
      for (int i = 0; i < NUM_BULLETS; i++) begin
         cov_c[i] = act_q[i]
                 && ({1'b0, bus.xx} >= {1'b0, bx_q[i]})
                 && ({1'b0, bus.xx} <  ({1'b0, bx_q[i]} + 11'(SIZE)))
                 && ({1'b0, bus.yy} >= {1'b0, by_q[i]})
                 && ({1'b0, bus.yy} <  ({1'b0, by_q[i]} + 11'(SIZE)));
      end
      newhit_c = cov_c & {NUM_BULLETS{bus.HeartSpriteOn && bus.aactive}};
   end

   // Next-state logic: collision capture during SCAN, move/spawn/retire on UPDATE.
   always_comb begin
      act_d     = act_q;
      flag_d    = flag_q;
      bx_d      = bx_q;
      by_d      = by_q;
      cnt_d     = cnt_q;
      lfsr_d    = lfsr_q;
      hcnt_d    = hcnt_q;
      hit_d     = 1'b0;
      bso_d     = bus.aactive && (|cov_c);
      spawned_c = 1'b0;

      if (phase_c == SCAN) begin
         flag_d = flag_q | newhit_c;
      end else if (!en_c) begin
         act_d  = '0;
         flag_d = '0;
         cnt_d  = '0;
      end else begin
         if (|flag_q) begin
            hit_d = 1'b1;
            if (hcnt_q != 4'd15) hcnt_d = hcnt_q + 4'd1;
         end
         for (int i = 0; i < NUM_BULLETS; i++) begin
            if (flag_q[i]) begin
               act_d[i] = 1'b0;
            end else if (act_q[i]) begin
               if (({1'b0, bx_q[i]} - 11'(SPEED)) < 11'(BOX_X0)) act_d[i] = 1'b0;
               else                                             bx_d[i]  = bx_q[i] - 10'(SPEED);
            end
         end
         // Overlaps seen on the tick itself belong to the next frame.
         flag_d = newhit_c;
         if (cnt_q == CW'(SPAWN_FRAMES - 1)) begin
            cnt_d = '0;
            for (int i = 0; i < NUM_BULLETS; i++) begin
               if (!spawned_c && !act_d[i]) begin
                  spawned_c = 1'b1;
                  act_d[i]  = 1'b1;
                  bx_d[i]   = 10'(BOX_X1 - SIZE);
                  by_d[i]   = 10'(BOX_Y0) + 10'(lfsr_q[5:0]);
               end
            end
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
         lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      end
   end

   // State and output registers.
   always_ff @(posedge Pclk) begin
      if (RESET) begin
         act_q  <= '0;
         flag_q <= '0;
         cnt_q  <= '0;
         lfsr_q <= 8'hA5;
         bso_q  <= 1'b0;
         hit_q  <= 1'b0;
         hcnt_q <= 4'd0;
         for (int i = 0; i < NUM_BULLETS; i++) begin
            bx_q[i] <= 10'd0;
            by_q[i] <= 10'd0;
         end
      end else begin
         act_q  <= act_d;
         flag_q <= flag_d;
         cnt_q  <= cnt_d;
         lfsr_q <= lfsr_d;
         bso_q  <= bso_d;
         hit_q  <= hit_d;
         hcnt_q <= hcnt_d;
         for (int i = 0; i < NUM_BULLETS; i++) begin
            bx_q[i] <= bx_d[i];
            by_q[i] <= by_d[i];
         end
      end
   end

   assign bus.BulletSpriteOn = bso_q;
   assign bus.hit            = hit_q;
   assign bus.hit_count      = hcnt_q;

endmodule

// File: tb/tb_bullet_engine.sv
// Directed bench for bullet_engine with a reference bullet model and an expected-output queue.
module tb_bullet_engine;

   localparam int NB = 4;
   localparam int SZ = 8;
   localparam int SP = 2;
   localparam int SF = 1;
   localparam int X0 = 200;
   localparam int X1 = 440;
   localparam int Y0 = 260;

   logic Pclk;
   logic RESET;
   bullet_if bif ();

   bullet_engine #(
      .NUM_BULLETS(NB), .SIZE(SZ), .SPEED(SP), .SPAWN_FRAMES(SF),
      .BOX_X0(X0), .BOX_X1(X1), .BOX_Y0(Y0), .BOX_Y1(420), .FIGHT_STATE(3'd2)
   ) dut (
      .Pclk  (Pclk),
      .RESET (RESET),
      .bus   (bif.slave)
   );

   initial Pclk = 1'b0;
   always #20 Pclk = ~Pclk;

   int vectors     = 0;
   int miscompares = 0;

   // Reference bullet model
   int       mbx [NB];
   int       mby [NB];
   bit       mact[NB];
   bit       mflag[NB];
   int       mcnt;
   int       mhcnt;
   logic [7:0] mlfsr;
   bit       exp_q[$];

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NB; i++) begin
         mbx[i] = 0; mby[i] = 0; mact[i] = 0; mflag[i] = 0;
      end
      mcnt = 0; mhcnt = 0; mlfsr = 8'hA5;
   endtask

   // One clock: drive inputs, predict, then compare registered outputs after the edge.
   task automatic step(input bit r, input int x, input int y, input bit a,
                       input logic [2:0] st, input bit h);
      bit cv[NB];
      bit any_cv, exp_b, exp_hit, anyf, done;
      RESET = r;
      bif.xx = 10'(x); bif.yy = 10'(y); bif.aactive = a;
      bif.state = st; bif.HeartSpriteOn = h;
      any_cv = 0;
      for (int i = 0; i < NB; i++) begin
         cv[i] = mact[i] && x >= mbx[i] && x < mbx[i] + SZ && y >= mby[i] && y < mby[i] + SZ;
         any_cv |= cv[i];
      end
      exp_b = a && any_cv;
      exp_hit = 0;
      if (r) begin
         model_reset();
         exp_b = 0;
      end else if (x == 0 && y == 480) begin
         if (st != 3'd2) begin
            for (int i = 0; i < NB; i++) begin mact[i] = 0; mflag[i] = 0; end
            mcnt = 0;
         end else begin
            anyf = 0;
            for (int i = 0; i < NB; i++) anyf |= mflag[i];
            if (anyf) begin
               exp_hit = 1;
               if (mhcnt < 15) mhcnt++;
            end
            for (int i = 0; i < NB; i++) begin
               if (mflag[i]) mact[i] = 0;
               else if (mact[i]) begin
                  if (mbx[i] - SP < X0) mact[i] = 0;
                  else mbx[i] -= SP;
               end
               mflag[i] = cv[i] && h && a;
            end
            if (mcnt == SF - 1) begin
               mcnt = 0;
               done = 0;
               for (int i = 0; i < NB; i++) begin
                  if (!done && !mact[i]) begin
                     done = 1; mact[i] = 1; mbx[i] = X1 - SZ; mby[i] = Y0 + int'(mlfsr[5:0]);
                  end
               end
            end else mcnt++;
            mlfsr = {mlfsr[6:0], mlfsr[7] ^ mlfsr[5] ^ mlfsr[4] ^ mlfsr[3]};
         end
      end else begin
         for (int i = 0; i < NB; i++) mflag[i] |= cv[i] && h && a;
      end
      exp_q.push_back(exp_b);
      @(posedge Pclk);
      #1;
      chk("bullet_on", {3'b0, bif.BulletSpriteOn}, {3'b0, exp_q.pop_front()});
      chk("hit", {3'b0, bif.hit}, {3'b0, exp_hit});
      chk("hit_count", bif.hit_count, 4'(mhcnt));
   endtask

   task automatic tick(input logic [2:0] st);
      step(0, 0, 480, 0, st, 0);
   endtask

   // Probes corners of every modelled bullet plus two random box pixels.
   task automatic probe_frame(input logic [2:0] st);
      for (int i = 0; i < NB; i++) begin
         step(0, mbx[i], mby[i], 1, st, 0);
         step(0, mbx[i] + SZ - 1, mby[i] + SZ - 1, 1, st, 0);
      end
      for (int k = 0; k < 2; k++)
         step(0, int'($urandom_range(190, 450)), int'($urandom_range(250, 430)), 1, st, 0);
   endtask

   int hits_done;
   int j;

   initial begin
      RESET = 1'b1;
      bif.xx = '0; bif.yy = '0; bif.aactive = 1'b0; bif.state = 3'd0; bif.HeartSpriteOn = 1'b0;
      model_reset();

      // Reset state
      step(1, 5, 5, 0, 3'd0, 0);
      step(1, 5, 5, 0, 3'd0, 0);
      chk("rst_bso", {3'b0, bif.BulletSpriteOn}, 4'd0);
      chk("rst_hcnt", bif.hit_count, 4'd0);

      // Two idle frames outside the fight
      for (int f = 0; f < 2; f++) begin
         tick(3'd0);
         step(0, 432, 297, 1, 3'd0, 1);
         probe_frame(3'd0);
      end

      // First spawn lands at (432,297)
      tick(3'd2);
      step(0, 432, 297, 1, 3'd2, 0);
      chk("spawn_tl", {3'b0, bif.BulletSpriteOn}, 4'd1);
      step(0, 439, 304, 1, 3'd2, 0);
      chk("spawn_br", {3'b0, bif.BulletSpriteOn}, 4'd1);
      step(0, 431, 297, 1, 3'd2, 0);
      chk("spawn_left", {3'b0, bif.BulletSpriteOn}, 4'd0);
      step(0, 440, 297, 1, 3'd2, 0);
      step(0, 432, 305, 1, 3'd2, 0);
      step(0, 435, 300, 0, 3'd2, 0);
      chk("blank_area", {3'b0, bif.BulletSpriteOn}, 4'd0);

      // Fill the pool, drop spawns, march bullets out of the box
      for (int f = 0; f < 120; f++) begin
         tick(3'd2);
         probe_frame(3'd2);
      end

      // Single collision
      j = 0;
      for (int i = NB - 1; i >= 0; i--) if (mact[i]) j = i;
      step(0, mbx[j] + 3, mby[j] + 3, 1, 3'd2, 1);
      tick(3'd2);
      chk("hit_pulse", {3'b0, bif.hit}, 4'd1);
      chk("hcnt_one", bif.hit_count, 4'd1);
      probe_frame(3'd2);
      chk("hit_one_cycle", {3'b0, bif.hit}, 4'd0);

      // Saturate the collision count
      hits_done = 1;
      for (int f = 0; f < 60 && hits_done < 17; f++) begin
         j = -1;
         for (int i = NB - 1; i >= 0; i--) if (mact[i]) j = i;
         if (j >= 0) begin
            step(0, mbx[j], mby[j], 1, 3'd2, 1);
            hits_done++;
         end
         tick(3'd2);
         probe_frame(3'd2);
      end
      chk("hcnt_sat", bif.hit_count, 4'd15);

      // Leaving the fight clears bullets and pending flags, keeps the count
      j = 0;
      for (int i = NB - 1; i >= 0; i--) if (mact[i]) j = i;
      step(0, mbx[j], mby[j], 1, 3'd2, 1);
      tick(3'd0);
      chk("exit_no_hit", {3'b0, bif.hit}, 4'd0);
      chk("exit_hcnt", bif.hit_count, 4'd15);
      probe_frame(3'd0);
      tick(3'd2);
      chk("reenter_no_hit", {3'b0, bif.hit}, 4'd0);

      // Reset in the middle of a line with a pending collision
      for (int f = 0; f < 3; f++) begin
         tick(3'd2);
         probe_frame(3'd2);
      end
      step(0, mbx[0], mby[0], 1, 3'd2, 1);
      step(1, mbx[0] + 1, mby[0], 1, 3'd2, 1);
      chk("midrst_bso", {3'b0, bif.BulletSpriteOn}, 4'd0);
      chk("midrst_hcnt", bif.hit_count, 4'd0);
      tick(3'd2);
      chk("midrst_no_hit", {3'b0, bif.hit}, 4'd0);
      probe_frame(3'd2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
